tiled_matmul_accumulator: RTL and testbench



---
 rtl/tiled_mma_pkg.sv | 18 +
 rtl/matmul_tile_product.sv | 45 ++++
 rtl/tiled_matmul_accumulator.sv | 123 ++++++++++++
 tb/tb_tiled_matmul_accumulator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiled_mma_pkg.sv
// Shared types and sizing helpers for the tiled matrix multiply-accumulate engine.
package tiled_mma_pkg;

  localparam int unsigned DefP     = 8;
  localparam int unsigned DefAccW  = 4 * DefP;
  localparam int unsigned DefProdW = 2 * DefP;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  function automatic int unsigned prod_w(input int unsigned p);
    return 2 * p;
  endfunction

endpackage

// File: rtl/matmul_tile_product.sv
// Combinational M x N array of K-element dot products over one A-tile and one B-tile.
module matmul_tile_product
  import tiled_mma_pkg::*;
#(
  parameter int unsigned M     = 2,
  parameter int unsigned N     = 2,
  parameter int unsigned K     = 4,
  parameter int unsigned P     = DefP,
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic [M-1:0][K-1:0][P-1:0]     a_i,
  input  logic [K-1:0][N-1:0][P-1:0]     b_i,
  input  logic                           signed_mode_i,
  output logic [M-1:0][N-1:0][ACC_W-1:0] sum_o
);

  localparam int unsigned PW = prod_w(P);

  // Operands are extended to 2P so the low 2P bits hold the exact product in either mode.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [P-1:0] a, input logic [P-1:0] b,
                                               input logic sgn);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] pr;
    ax = sgn ? {{P{a[P-1]}}, a} : {{P{1'b0}}, a};
    bx = sgn ? {{P{b[P-1]}}, b} : {{P{1'b0}}, b};
    pr = ax * bx;
    if (sgn) begin
      return ACC_W'($signed(pr));
    end
    return ACC_W'(pr);
  endfunction

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < int'(M); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        for (int k = 0; k < int'(K); k++) begin
          sum_o[i][j] = sum_o[i][j] + mul_ext(a_i[i][k], b_i[k][j], signed_mode_i);
        end
      end
    end
  end

endmodule

// File: rtl/tiled_matmul_accumulator.sv
// Output-stationary K-tiled MMA: D = C + sum of A_t*B_t over a runtime number of beats.
module tiled_matmul_accumulator
  import tiled_mma_pkg::*;
#(
  parameter int unsigned M     = 2,
  parameter int unsigned N     = 2,
  parameter int unsigned K     = 4,
  parameter int unsigned P     = DefP,
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned KT_W  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic [M-1:0][K-1:0][P-1:0]     A,
  input  logic [K-1:0][N-1:0][P-1:0]     B,
  input  logic [M-1:0][N-1:0][ACC_W-1:0] C,
  input  logic [KT_W-1:0]                k_tiles,
  input  logic                           signed_mode,
  output logic [M-1:0][N-1:0][ACC_W-1:0] D,
  output logic                           valid_out,
  input  logic                           ready_out
);

  state_e                         state_q, state_d;
  logic [KT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [KT_W-1:0]                k_tiles_q, k_tiles_d;
  logic                           signed_q, signed_d;
  logic [M-1:0][N-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [M-1:0][N-1:0][ACC_W-1:0] prod;
  logic                           prod_signed;
  logic [KT_W-1:0]                kt_eff;
  logic [KT_W-1:0]                cnt_inc;

  // The first beat of a job uses the live signed_mode; later beats use the latched copy.
  assign prod_signed = (state_q == StIdle) ? signed_mode : signed_q;

  matmul_tile_product #(
    .M     (M),
    .N     (N),
    .K     (K),
    .P     (P),
    .ACC_W (ACC_W)
  ) u_product (
    .a_i           (A),
    .b_i           (B),
    .signed_mode_i (prod_signed),
    .sum_o         (prod)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      k_tiles_q  <= '0;
      signed_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      k_tiles_q  <= k_tiles_d;
      signed_q   <= signed_d;
      acc_q      <= acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    k_tiles_d  = k_tiles_q;
    signed_d   = signed_q;
    acc_d      = acc_q;
    cnt_inc    = beat_cnt_q + KT_W'(1);
    kt_eff     = (k_tiles == '0) ? KT_W'(1) : k_tiles;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          k_tiles_d = kt_eff;
          signed_d  = signed_mode;
          for (int i = 0; i < int'(M); i++) begin
            for (int j = 0; j < int'(N); j++) begin
              acc_d[i][j] = C[i][j] + prod[i][j];
            end
          end
          if (kt_eff == KT_W'(1)) begin
            state_d = StDone;
          end else begin
            state_d    = StAccum;
            beat_cnt_d = KT_W'(1);
          end
        end
      end
      StAccum: begin
        if (valid_in) begin
          for (int i = 0; i < int'(M); i++) begin
            for (int j = 0; j < int'(N); j++) begin
              acc_d[i][j] = acc_q[i][j] + prod[i][j];
            end
          end
          beat_cnt_d = cnt_inc;
          if (cnt_inc == k_tiles_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (ready_out) begin
          state_d    = StIdle;
          beat_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_in  = (state_q != StDone);
    valid_out = (state_q == StDone);
    D         = acc_q;
  end

endmodule

// File: tb/tb_tiled_matmul_accumulator.sv
// Randomised bench for tiled_matmul_accumulator against an arithmetic job-level model.
module tb_tiled_matmul_accumulator;

  localparam int unsigned M     = 2;
  localparam int unsigned N     = 2;
  localparam int unsigned K     = 4;
  localparam int unsigned P     = 8;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned KT_W  = 8;

  typedef logic [M-1:0][K-1:0][P-1:0]     a_t;
  typedef logic [K-1:0][N-1:0][P-1:0]     b_t;
  typedef logic [M-1:0][N-1:0][ACC_W-1:0] d_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            valid_in = 1'b0;
  logic            ready_in;
  a_t              A = '0;
  b_t              B = '0;
  d_t              C = '0;
  logic [KT_W-1:0] k_tiles = '0;
  logic            signed_mode = 1'b0;
  d_t              D;
  logic            valid_out;
  logic            ready_out = 1'b0;

  int checks = 0;
  int errors = 0;

  // Job-level reference state
  d_t m_acc;
  int m_kt  = 0;
  int m_cnt = 0;
  bit m_sgn = 1'b0;

  tiled_matmul_accumulator #(
    .M     (M),
    .N     (N),
    .K     (K),
    .P     (P),
    .ACC_W (ACC_W),
    .KT_W  (KT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .A           (A),
    .B           (B),
    .C           (C),
    .k_tiles     (k_tiles),
    .signed_mode (signed_mode),
    .D           (D),
    .valid_out   (valid_out),
    .ready_out   (ready_out)
  );

  always #5 clk_i = ~clk_i;

  function automatic a_t fill_a(input logic [P-1:0] v);
    a_t r;
    for (int i = 0; i < int'(M); i++) for (int k = 0; k < int'(K); k++) r[i][k] = v;
    return r;
  endfunction

  function automatic b_t fill_b(input logic [P-1:0] v);
    b_t r;
    for (int k = 0; k < int'(K); k++) for (int j = 0; j < int'(N); j++) r[k][j] = v;
    return r;
  endfunction

  function automatic d_t fill_d(input logic [ACC_W-1:0] v);
    d_t r;
    for (int i = 0; i < int'(M); i++) for (int j = 0; j < int'(N); j++) r[i][j] = v;
    return r;
  endfunction

  function automatic a_t rand_a();
    a_t r;
    for (int i = 0; i < int'(M); i++) for (int k = 0; k < int'(K); k++) r[i][k] = P'($urandom);
    return r;
  endfunction

  function automatic b_t rand_b();
    b_t r;
    for (int k = 0; k < int'(K); k++) for (int j = 0; j < int'(N); j++) r[k][j] = P'($urandom);
    return r;
  endfunction

  function automatic d_t rand_d();
    d_t r;
    for (int i = 0; i < int'(M); i++) for (int j = 0; j < int'(N); j++) r[i][j] = $urandom;
    return r;
  endfunction

  // Exact integer dot product, reduced modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] dot(input a_t a, input b_t b, input bit sgn,
                                           input int i, input int j);
    longint s = 0;
    longint x;
    longint y;
    for (int k = 0; k < int'(K); k++) begin
      x = sgn ? longint'($signed(a[i][k])) : longint'({1'b0, a[i][k]});
      y = sgn ? longint'($signed(b[k][j])) : longint'({1'b0, b[k][j]});
      s += x * y;
    end
    return ACC_W'(s);
  endfunction

  task automatic model_beat(input a_t a, input b_t b, input d_t c, input int kt, input bit sgn);
    if (m_cnt == 0) begin
      m_kt  = (kt == 0) ? 1 : kt;
      m_sgn = sgn;
      for (int i = 0; i < int'(M); i++)
        for (int j = 0; j < int'(N); j++) m_acc[i][j] = c[i][j] + dot(a, b, sgn, i, j);
    end else begin
      for (int i = 0; i < int'(M); i++)
        for (int j = 0; j < int'(N); j++) m_acc[i][j] = m_acc[i][j] + dot(a, b, m_sgn, i, j);
    end
    m_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m_cnt = 0;
    m_acc = '0;
  endtask

  task automatic send(input a_t a, input b_t b, input d_t c, input int kt, input bit sgn,
                      output int waits);
    waits = 0;
    @(negedge clk_i);
    A = a;
    B = b;
    C = c;
    k_tiles = KT_W'(kt);
    signed_mode = sgn;
    valid_in = 1'b1;
    while (ready_in !== 1'b1 && waits < 50) begin
      @(negedge clk_i);
      waits++;
    end
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ready_in=%b required 1", ready_in);
      valid_in = 1'b0;
      return;
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL early_valid_out got %b required 0 (beat %0d)", valid_out, m_cnt);
    end
    @(posedge clk_i);
    #1;
    valid_in = 1'b0;
    model_beat(a, b, c, kt, sgn);
  endtask

  // Called #1 after the edge that accepted the last beat; stalls ready_out for 'stall' cycles.
  task automatic expect_result(input string name, input int stall);
    d_t exp;
    exp = m_acc;
    ready_out = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (valid_out !== 1'b1 || ready_in !== 1'b0) begin
        errors++;
        $display("FAIL %s_handshake cycle %0d valid_out=%b ready_in=%b required 1/0",
                 name, s, valid_out, ready_in);
      end
      checks++;
      if (D !== exp) begin
        errors++;
        $display("FAIL %s_data cycle %0d D=%h required %h", name, s, D, exp);
      end
      if (s == stall) ready_out = 1'b1;
      @(posedge clk_i);
      #1;
    end
    ready_out = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL %s_release valid_out=%b ready_in=%b required 0/1", name, valid_out,
               ready_in);
    end
    m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1 || D !== '0) begin
      errors++;
      $display("FAIL reset_state valid_out=%b ready_in=%b D=%h required 0/1/0", valid_out,
               ready_in, D);
    end
  endtask

  task automatic test_single_tile();
    int w;
    send(fill_a(8'd1), fill_b(8'd2), fill_d(32'd5), 1, 1'b1, w);
    expect_result("single_tile", 0);
  endtask

  task automatic test_multi_tile();
    int w;
    send(fill_a(8'd1), fill_b(8'd1), fill_d(32'd0), 3, 1'b1, w);
    send(fill_a(8'd1), fill_b(8'd1), fill_d(32'd100), 7, 1'b0, w);
    send(fill_a(8'd1), fill_b(8'd1), fill_d(32'd100), 1, 1'b0, w);
    expect_result("multi_tile", 0);
  endtask

  task automatic test_signed_unsigned();
    int w;
    send(fill_a(8'hFF), fill_b(8'h02), fill_d(32'd0), 1, 1'b1, w);
    expect_result("signed_mode", 1);
    send(fill_a(8'hFF), fill_b(8'h02), fill_d(32'd0), 1, 1'b0, w);
    expect_result("unsigned_mode", 1);
  endtask

  task automatic test_back_to_back();
    int w;
    send(rand_a(), rand_b(), rand_d(), 2, 1'b1, w);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk_i);
      checks++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
        errors++;
        $display("FAIL gap_hold cycle %0d valid_out=%b ready_in=%b required 0/1", g,
                 valid_out, ready_in);
      end
    end
    send(rand_a(), rand_b(), rand_d(), 9, 1'b0, w);
    expect_result("backpressure", 4);
    send(rand_a(), rand_b(), rand_d(), 1, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL next_job_accept waited %0d cycles required 0", w);
    end
    expect_result("after_handshake", 0);
  endtask

  task automatic test_wrap();
    int w;
    send(fill_a(8'd1), fill_b(8'd1), fill_d(32'h7FFF_FFFF), 1, 1'b1, w);
    expect_result("wrap", 0);
  endtask

  task automatic test_reset_mid_job();
    int w;
    // Reset while D is being presented
    send(rand_a(), rand_b(), rand_d(), 0, 1'b1, w);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || D !== '0) begin
      errors++;
      $display("FAIL reset_in_done valid_out=%b D=%h required 0/0", valid_out, D);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_cnt = 0;
    // Reset part-way through an accumulation
    send(rand_a(), rand_b(), rand_d(), 3, 1'b1, w);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || D !== '0) begin
      errors++;
      $display("FAIL reset_in_accum valid_out=%b D=%h required 0/0", valid_out, D);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_cnt = 0;
    send(fill_a(8'd1), fill_b(8'd1), fill_d(32'd0), 1, 1'b1, w);
    expect_result("post_reset_job", 0);
  endtask

  task automatic test_random_jobs();
    int w;
    int kt;
    int eff;
    for (int job = 0; job < 25; job++) begin
      kt = $urandom_range(0, 4);
      eff = (kt == 0) ? 1 : kt;
      for (int b = 0; b < eff; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        if (b == 0) send(rand_a(), rand_b(), rand_d(), kt, 1'($urandom), w);
        else send(rand_a(), rand_b(), rand_d(), $urandom_range(0, 255), 1'($urandom), w);
      end
      expect_result("random_job", $urandom_range(0, 3));
    end
  endtask

  task automatic test_k_max();
    int w;
    send(rand_a(), rand_b(), rand_d(), 255, 1'b1, w);
    for (int b = 1; b < 255; b++) send(rand_a(), rand_b(), rand_d(), 1, 1'b0, w);
    expect_result("k_max", 1);
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_signed_unsigned();
    test_back_to_back();
    test_wrap();
    test_reset_mid_job();
    test_random_jobs();
    test_k_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
